riscv_noicache_pfq_core: RTL and testbench

Instruction-fetch front end for cores built without an instruction cache. It issues pipelined fetch requests to the BIU and holds up to DEPTH outstanding transactions. Returned parcels go into a DEPTH-entry prefetch queue, so the CPU can back-pressure fetch without losing data. Flushes drop queued parcels and discard responses still in flight. It replaces the unbuffered no-icache fetch logic between the IF stage and the instruction BIU.

---
 rtl/riscv_noicache_pfq_core.sv | 168 ++++++++++++++++
 tb/tb_riscv_noicache_pfq_core.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_noicache_pfq_core.sv
// No-icache instruction fetch front end with pipelined BIU requests
// and a small prefetch queue so the CPU can stall without losing parcels.
package riscv_noicache_pfq_pkg;
    typedef logic [2:0] biu_prot_t;

    typedef enum logic [2:0] {
        BYTE  = 3'd0,
        HWORD = 3'd1,
        WORD  = 3'd2,
        DWORD = 3'd3,
        QWORD = 3'd4
    } biu_size_t;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } biu_type_t;
endpackage

module riscv_noicache_pfq_core
    import riscv_noicache_pfq_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int PLEN        = XLEN,
    parameter int PARCEL_SIZE = 16,
    parameter int HAS_RVC     = 0,
    parameter int DEPTH       = 2,
    parameter int BIUTAG_SIZE = $clog2(XLEN/PARCEL_SIZE)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,

    input  logic [XLEN-1:0]               if_nxt_pc_i,
    input  logic                          if_req_i,
    output logic                          if_ack_o,
    input  biu_prot_t                     if_prot_i,
    input  logic                          if_flush_i,
    input  logic                          if_parcel_rdy_i,
    output logic [XLEN-1:0]               if_parcel_pc_o,
    output logic [XLEN-1:0]               if_parcel_o,
    output logic [XLEN/PARCEL_SIZE-1:0]   if_parcel_valid_o,
    output logic                          if_parcel_misaligned_o,
    output logic                          if_parcel_error_o,

    input  logic                          dcflush_rdy_i,

    output logic                          biu_stb_o,
    input  logic                          biu_stb_ack_i,
    input  logic                          biu_d_ack_i,
    output logic [PLEN-1:0]               biu_adri_o,
    input  logic [PLEN-1:0]               biu_adro_i,
    output biu_size_t                     biu_size_o,
    output biu_type_t                     biu_type_o,
    output logic                          biu_lock_o,
    output logic                          biu_we_o,
    output biu_prot_t                     biu_prot_o,
    output logic [XLEN-1:0]               biu_d_o,
    input  logic [XLEN-1:0]               biu_q_i,
    input  logic                          biu_ack_i,
    input  logic                          biu_err_i,
    output logic [BIUTAG_SIZE-1:0]        biu_tagi_o,
    input  logic [BIUTAG_SIZE-1:0]        biu_tago_i
);

    localparam int NP = XLEN/PARCEL_SIZE;
    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CW-1:0]   inflight, discard, count, inflight_nxt;
    logic [CW:0]     used;
    logic [PW-1:0]   wp, rp;
    logic            flush_dly;

    logic [XLEN-1:0] pc_q   [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [NP-1:0]   mask_q [DEPTH];
    logic            err_q  [DEPTH];

    logic            resp, credit, push, pop, empty, show;
    logic [PLEN-1:0] rsp_addr;
    logic [XLEN-1:0] rsp_pc, head_pc;
    logic [NP-1:0]   rsp_mask;
    logic            unused;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    assign resp         = biu_ack_i | biu_err_i;
    assign used         = {1'b0, inflight} + {1'b0, count};
    assign credit       = used < (CW+1)'(DEPTH);
    assign inflight_nxt = inflight + CW'(biu_stb_ack_i) - CW'(resp);
    assign empty        = count == '0;
    assign push         = resp & (discard == '0) & ~if_flush_i;
    assign pop          = if_parcel_rdy_i & ~empty;

    assign rsp_addr = {biu_adro_i[PLEN-1:BIUTAG_SIZE+1], biu_tago_i, 1'b0};
    assign rsp_pc   = XLEN'(rsp_addr);
    assign rsp_mask = {NP{1'b1}} << biu_tago_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight  <= '0;
            discard   <= '0;
            count     <= '0;
            wp        <= '0;
            rp        <= '0;
            flush_dly <= 1'b0;
        end else begin
            inflight  <= inflight_nxt;
            flush_dly <= if_flush_i;
            if (if_flush_i) begin
                // responses for requests already issued must be thrown away
                discard <= inflight_nxt;
                count   <= '0;
                wp      <= '0;
                rp      <= '0;
            end else begin
                if (resp && discard != '0)
                    discard <= discard - CW'(1);
                if (push)
                    wp <= inc(wp);
                if (pop)
                    rp <= inc(rp);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_q[wp]   <= rsp_pc;
            data_q[wp] <= biu_q_i;
            mask_q[wp] <= rsp_mask;
            err_q[wp]  <= biu_err_i;
        end
    end

    assign show    = ~empty & ~if_flush_i & ~flush_dly;
    assign head_pc = pc_q[rp];

    assign if_parcel_pc_o         = head_pc;
    assign if_parcel_o            = data_q[rp];
    assign if_parcel_valid_o      = show ? mask_q[rp] : '0;
    assign if_parcel_error_o      = show & err_q[rp];
    assign if_parcel_misaligned_o = show &
        ((HAS_RVC != 0) ? head_pc[0] : |head_pc[1:0]);

    assign biu_stb_o  = dcflush_rdy_i & ~if_flush_i & if_req_i & credit;
    assign if_ack_o   = dcflush_rdy_i & biu_stb_ack_i;
    assign biu_adri_o = PLEN'(if_nxt_pc_i) & ~PLEN'(XLEN/8-1);
    assign biu_tagi_o = if_nxt_pc_i[1 +: BIUTAG_SIZE];
    assign biu_size_o = (XLEN == 64) ? DWORD : WORD;
    assign biu_type_o = INCR;
    assign biu_lock_o = 1'b0;
    assign biu_we_o   = 1'b0;
    assign biu_d_o    = '0;
    assign biu_prot_o = if_prot_i;

    assign unused = ^{biu_d_ack_i, biu_adro_i[BIUTAG_SIZE:0]};

endmodule

// File: tb/tb_riscv_noicache_pfq_core.sv
// Directed bench for the no-icache prefetch queue front end,
// with a queue-based scoreboard checked by an independent monitor.
module tb_riscv_noicache_pfq_core;
    import riscv_noicache_pfq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] nxt_pc;
    logic        req, ack_o, flush, rdy, dcflush;
    biu_prot_t   prot, biu_prot;
    logic [31:0] parcel_pc, parcel;
    logic [1:0]  parcel_valid;
    logic        parcel_mis, parcel_err;
    logic        stb, stb_ack, d_ack, lock, we, b_ack, b_err;
    logic [31:0] adri, adro, d_o, q_i;
    biu_size_t   size;
    biu_type_t   btype;
    logic        tagi, tago;

    riscv_noicache_pfq_core #(
        .XLEN(32), .PLEN(32), .PARCEL_SIZE(16), .HAS_RVC(1), .DEPTH(2)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .if_nxt_pc_i(nxt_pc), .if_req_i(req), .if_ack_o(ack_o),
        .if_prot_i(prot), .if_flush_i(flush), .if_parcel_rdy_i(rdy),
        .if_parcel_pc_o(parcel_pc), .if_parcel_o(parcel),
        .if_parcel_valid_o(parcel_valid),
        .if_parcel_misaligned_o(parcel_mis),
        .if_parcel_error_o(parcel_err),
        .dcflush_rdy_i(dcflush),
        .biu_stb_o(stb), .biu_stb_ack_i(stb_ack), .biu_d_ack_i(d_ack),
        .biu_adri_o(adri), .biu_adro_i(adro), .biu_size_o(size),
        .biu_type_o(btype), .biu_lock_o(lock), .biu_we_o(we),
        .biu_prot_o(biu_prot), .biu_d_o(d_o), .biu_q_i(q_i),
        .biu_ack_i(b_ack), .biu_err_i(b_err),
        .biu_tagi_o(tagi), .biu_tago_i(tago)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic [1:0]  valid;
        logic        err;
        logic        mis;
    } ent_t;

    ent_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [79:0] act,
                       input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        ent_t act;
        if (!rst && (|parcel_valid) && rdy) begin
            act = {parcel_pc, parcel, parcel_valid, parcel_err, parcel_mis};
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_parcel: got %0h expected none", act);
            end else begin
                chk("parcel", act, exp_q.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stb_ack = 1'b0;
        b_ack   = 1'b0;
        b_err   = 1'b0;
    endtask

    task automatic rsp(input logic [31:0] a, input logic t,
                       input logic [31:0] q, input logic e);
        adro  = a;
        tago  = t;
        q_i   = q;
        b_ack = ~e;
        b_err = e;
    endtask

    task automatic expect_ent(input logic [31:0] pc, input logic [31:0] d,
                              input logic [1:0] v, input logic e);
        exp_q.push_back('{pc: pc, data: d, valid: v, err: e, mis: 1'b0});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; nxt_pc = '0; req = 1'b0; flush = 1'b0; rdy = 1'b1;
        dcflush = 1'b1; prot = 3'b101; stb_ack = 1'b0; d_ack = 1'b0;
        adro = '0; q_i = '0; b_ack = 1'b0; b_err = 1'b0; tago = 1'b0;
        cyc();
        cyc();
        #1;
        chk("rst_valid", 80'(parcel_valid), 80'd0);
        chk("rst_err", 80'(parcel_err), 80'd0);
        chk("rst_mis", 80'(parcel_mis), 80'd0);
        chk("rst_stb", 80'(stb), 80'd0);
        cyc();
        rst = 1'b0;

        // basic fetch, ack two cycles after stb_ack
        cyc();
        req = 1'b1; nxt_pc = 32'h100; stb_ack = 1'b1;
        #1;
        chk("t1_stb", 80'(stb), 80'd1);
        chk("t1_ack", 80'(ack_o), 80'd1);
        chk("t1_adri", 80'(adri), 80'h100);
        chk("t1_tagi", 80'(tagi), 80'd0);
        chk("t1_size", 80'(size), 80'(WORD));
        chk("t1_type", 80'(btype), 80'(INCR));
        chk("t1_prot", 80'(biu_prot), 80'(3'b101));
        chk("t1_fixed", 80'({lock, we, d_o}), 80'd0);
        expect_ent(32'h100, 32'h0013_0013, 2'b11, 1'b0);
        cyc();
        req = 1'b0; stb_ack = 1'b0;
        cyc();
        rsp(32'h100, 1'b0, 32'h0013_0013, 1'b0);
        #1;
        chk("t1_nobypass", 80'(parcel_valid), 80'd0);
        cyc();
        idle();
        #1;
        chk("t1_lat_valid", 80'(parcel_valid), 80'(2'b11));
        chk("t1_lat_pc", 80'(parcel_pc), 80'h100);

        // back-pressure: credit limits to two outstanding
        cyc();
        rdy = 1'b0; req = 1'b1; nxt_pc = 32'h104; stb_ack = 1'b1;
        #1;
        chk("t2_stb0", 80'(stb), 80'd1);
        expect_ent(32'h104, 32'hAAAA_0001, 2'b11, 1'b0);
        cyc();
        nxt_pc = 32'h108;
        #1;
        chk("t2_stb1", 80'(stb), 80'd1);
        expect_ent(32'h108, 32'hAAAA_0002, 2'b11, 1'b0);
        cyc();
        stb_ack = 1'b0;
        #1;
        chk("t2_full_a", 80'(stb), 80'd0);
        rsp(32'h104, 1'b0, 32'hAAAA_0001, 1'b0);
        cyc();
        #1;
        chk("t2_full_b", 80'(stb), 80'd0);
        rsp(32'h108, 1'b0, 32'hAAAA_0002, 1'b0);
        cyc();
        idle();
        #1;
        chk("t2_full_c", 80'(stb), 80'd0);
        chk("t2_head_pc", 80'(parcel_pc), 80'h104);
        cyc();
        #1;
        chk("t2_hold_pc", 80'(parcel_pc), 80'h104);
        cyc();
        req = 1'b0; rdy = 1'b1;
        cyc();
        cyc();
        #1;
        chk("t2_drained", 80'(parcel_valid), 80'd0);

        // flush with two in flight, acks 1 and 3 cycles later
        cyc();
        req = 1'b1; nxt_pc = 32'h110; stb_ack = 1'b1;
        cyc();
        nxt_pc = 32'h114;
        cyc();
        req = 1'b0; stb_ack = 1'b0; flush = 1'b1;
        cyc();
        flush = 1'b0;
        rsp(32'h110, 1'b0, 32'hBAD0_0001, 1'b0);
        #1;
        chk("t3_dly_valid", 80'(parcel_valid), 80'd0);
        cyc();
        idle();
        cyc();
        rsp(32'h114, 1'b0, 32'hBAD0_0002, 1'b0);
        cyc();
        idle();
        #1;
        chk("t3_dropped", 80'(parcel_valid), 80'd0);
        cyc();
        req = 1'b1; nxt_pc = 32'h200; stb_ack = 1'b1;
        #1;
        chk("t3_stb", 80'(stb), 80'd1);
        expect_ent(32'h200, 32'hCCCC_0200, 2'b11, 1'b0);
        cyc();
        req = 1'b0; stb_ack = 1'b0;
        cyc();
        rsp(32'h200, 1'b0, 32'hCCCC_0200, 1'b0);
        cyc();
        idle();
        #1;
        chk("t3_valid", 80'(parcel_valid), 80'(2'b11));

        // flush coincident with an ack while two are in flight
        cyc();
        req = 1'b1; nxt_pc = 32'h120; stb_ack = 1'b1;
        cyc();
        nxt_pc = 32'h124;
        cyc();
        req = 1'b0; stb_ack = 1'b0; flush = 1'b1;
        rsp(32'h120, 1'b0, 32'hBAD0_0003, 1'b0);
        #1;
        chk("t4_flush_valid", 80'(parcel_valid), 80'd0);
        cyc();
        flush = 1'b0;
        rsp(32'h124, 1'b0, 32'hBAD0_0004, 1'b0);
        cyc();
        idle();
        #1;
        chk("t4_dropped", 80'(parcel_valid), 80'd0);
        cyc();
        req = 1'b1; nxt_pc = 32'h128; stb_ack = 1'b1;
        expect_ent(32'h128, 32'hDDDD_0128, 2'b11, 1'b0);
        cyc();
        req = 1'b0; stb_ack = 1'b0;
        rsp(32'h128, 1'b0, 32'hDDDD_0128, 1'b0);
        cyc();
        idle();

        // flush blocks strobe; error response on an upper parcel
        cyc();
        req = 1'b1; nxt_pc = 32'h102; flush = 1'b1;
        #1;
        chk("t5_stb_flush", 80'(stb), 80'd0);
        cyc();
        flush = 1'b0; stb_ack = 1'b1;
        #1;
        chk("t5_stb", 80'(stb), 80'd1);
        chk("t5_adri", 80'(adri), 80'h100);
        chk("t5_tagi", 80'(tagi), 80'd1);
        expect_ent(32'h102, 32'hDEAD_BEEF, 2'b10, 1'b1);
        cyc();
        req = 1'b0; stb_ack = 1'b0;
        rsp(32'h100, 1'b1, 32'hDEAD_BEEF, 1'b1);
        cyc();
        idle();
        #1;
        chk("t5_valid", 80'(parcel_valid), 80'(2'b10));
        chk("t5_err", 80'(parcel_err), 80'd1);
        chk("t5_mis", 80'(parcel_mis), 80'd0);

        // data-cache flush pending stalls fetch
        cyc();
        dcflush = 1'b0; req = 1'b1; nxt_pc = 32'h130;
        #1;
        chk("t6_stb_a", 80'(stb), 80'd0);
        stb_ack = 1'b1;
        #1;
        chk("t6_ack", 80'(ack_o), 80'd0);
        stb_ack = 1'b0;
        cyc();
        #1;
        chk("t6_stb_b", 80'(stb), 80'd0);
        cyc();
        dcflush = 1'b1; stb_ack = 1'b1;
        #1;
        chk("t6_stb_c", 80'(stb), 80'd1);
        chk("t6_ack_c", 80'(ack_o), 80'd1);
        expect_ent(32'h130, 32'hEEEE_0130, 2'b11, 1'b0);
        cyc();
        req = 1'b0; stb_ack = 1'b0;
        rsp(32'h130, 1'b0, 32'hEEEE_0130, 1'b0);
        cyc();
        idle();

        // reset with a queued entry and one in flight
        cyc();
        rdy = 1'b0; req = 1'b1; nxt_pc = 32'h140; stb_ack = 1'b1;
        cyc();
        req = 1'b0; stb_ack = 1'b0;
        rsp(32'h140, 1'b0, 32'hFFFF_0140, 1'b0);
        cyc();
        idle();
        req = 1'b1; nxt_pc = 32'h144; stb_ack = 1'b1;
        #1;
        chk("t7_pre_valid", 80'(parcel_valid), 80'(2'b11));
        cyc();
        req = 1'b0; stb_ack = 1'b0; rst = 1'b1;
        cyc();
        rst = 1'b0; rdy = 1'b1;
        #1;
        chk("t7_rst_valid", 80'(parcel_valid), 80'd0);
        req = 1'b1; nxt_pc = 32'h148;
        #1;
        chk("t7_rst_credit", 80'(stb), 80'd1);
        req = 1'b0;

        cyc();
        cyc();
        chk("sb_empty", 80'(exp_q.size()), 80'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
